// File: rtl/cpu_wrapper_1.sv
// cpu_wrapper_1: single-cycle 8-bit CPU, four registers, Harvard view of a dual-port memory
// Define SHIFT_ROTATE_EN to make opcode 8 execute SHL/SHR/RLC/RRC; otherwise it is a NOP.
module cpu_wrapper_1 (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] CCR_out,
    output logic [7:0] mem_addr_a,
    input  logic [7:0] Instr_in,
    output logic       mem_write_enable,
    output logic [7:0] mem_addr_b,
    output logic [7:0] mem_write_data_b,
    input  logic [7:0] mem_data_out_b
);
    logic [7:0] pc;
    logic [7:0] r [4];
    logic [3:0] ccr, ccr_n;
    logic       halted, imm_pending;
    logic [1:0] ra_lat;
    logic [3:0] op;
    logic [1:0] ra, rb, dst;
    logic [7:0] a, b, ax, ay, res, pc_n;
    logic [8:0] sum;
    logic       asub, ov, wr, c_n, v_n, zn_upd, halt_n, pend_n, mem_op;

    assign op = Instr_in[7:4];
    assign ra = Instr_in[3:2];
    assign rb = Instr_in[1:0];
    assign a = r[ra];
    assign b = r[rb];
    assign dst = imm_pending ? ra_lat : ra;
    assign mem_op = !imm_pending && (op == 4'hA || op == 4'hB);
    assign mem_addr_a = pc;
    assign CCR_out = ccr;
    assign mem_addr_b = mem_op ? b : 8'd0;
    assign mem_write_data_b = a;
    assign mem_write_enable = !rst && !halted && !imm_pending && op == 4'hB;

    // Shared adder: ADD/SUB use ra,rb; NEG is 0-ra; INC/DEC use ra with constant 1
    assign ax = (op == 4'h7 && rb == 2'd1) ? 8'd0 : a;
    assign ay = op == 4'h7 ? (rb[1] ? 8'd1 : a) : b;
    assign asub = op == 4'h3 || (op == 4'h7 && rb != 2'd2);
    assign sum = asub ? {1'b0, ax} - {1'b0, ay} : {1'b0, ax} + {1'b0, ay};
    assign ov = asub ? (ax[7] ^ ay[7]) & (sum[7] ^ ax[7]) : ~(ax[7] ^ ay[7]) & (sum[7] ^ ax[7]);

    always_comb begin
        res = a;
        wr = 1'b0;
        c_n = ccr[2];
        v_n = ccr[3];
        zn_upd = 1'b0;
        halt_n = halted;
        pend_n = 1'b0;
        pc_n = pc + 8'd1;
        if (imm_pending) begin
            wr = 1'b1;
            res = Instr_in;
        end else begin
            case (op)
                4'h1: begin wr = 1'b1; res = b; end
                4'h2, 4'h3: begin wr = 1'b1; zn_upd = 1'b1; res = sum[7:0]; c_n = sum[8]; v_n = ov; end
                4'h4: begin wr = 1'b1; zn_upd = 1'b1; res = a & b; end
                4'h5: begin wr = 1'b1; zn_upd = 1'b1; res = a | b; end
                4'h6: begin wr = 1'b1; zn_upd = 1'b1; res = a ^ b; end
                4'h7: begin
                    wr = 1'b1;
                    zn_upd = 1'b1;
                    res = rb == 2'd0 ? ~a : sum[7:0];
                    c_n = rb == 2'd0 ? ccr[2] : sum[8];
                    v_n = rb == 2'd0 ? ccr[3] : ov;
                end
`ifdef SHIFT_ROTATE_EN
                4'h8: begin
                    wr = 1'b1;
                    zn_upd = 1'b1;
                    c_n = rb[0] ? a[0] : a[7];
                    res = rb[0] ? {rb[1] & ccr[2], a[7:1]} : {a[6:0], rb[1] & ccr[2]};
                end
`endif
                4'h9: pend_n = 1'b1;
                4'hA: begin wr = 1'b1; res = mem_data_out_b; end
                4'hC: pc_n = (&ra || ccr[ra]) ? b : pc + 8'd1;
                4'hD: c_n = ra[1] ? ccr[2] : !ra[0];
                4'hF: begin halt_n = 1'b1; pc_n = pc; end
                default: ;
            endcase
        end
    end

    assign ccr_n = {v_n, c_n, zn_upd ? res[7] : ccr[1], zn_upd ? res == 8'd0 : ccr[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 8'd0;
            r <= '{default: 8'd0};
            ccr <= 4'd0;
            halted <= 1'b0;
            imm_pending <= 1'b0;
            ra_lat <= 2'd0;
        end else if (!halted) begin
            pc <= pc_n;
            ccr <= ccr_n;
            halted <= halt_n;
            imm_pending <= pend_n;
            if (!imm_pending) ra_lat <= ra;
            if (wr) r[dst] <= res;
        end
    end
endmodule

// File: tb/tb_cpu_wrapper_1.sv
// tb_cpu_wrapper_1: random and directed programs against an instruction-level reference model
module tb_cpu_wrapper_1;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] CCR_out;
    logic [7:0] mem_addr_a, Instr_in, mem_addr_b, mem_write_data_b, mem_data_out_b;
    logic       mem_write_enable;
    logic [7:0] mem [256];
    logic [7:0] mm [256];
    logic [7:0] prog [$];
    logic       peek_en = 1'b0;
    logic [7:0] peek_byte = 8'd0;
    int vectors = 0, errors = 0;
    int m_pc, m_lat, m_res;
    int m_r [4];
    int pv [4];
    bit m_z, m_n, m_c, m_v, m_halt, m_pend;

    cpu_wrapper_1 dut (
        .clk(clk), .rst(rst), .CCR_out(CCR_out), .mem_addr_a(mem_addr_a), .Instr_in(Instr_in),
        .mem_write_enable(mem_write_enable), .mem_addr_b(mem_addr_b),
        .mem_write_data_b(mem_write_data_b), .mem_data_out_b(mem_data_out_b)
    );

    assign Instr_in = peek_en ? peek_byte : mem[mem_addr_a];
    assign mem_data_out_b = mem[mem_addr_b];

    always #10 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return x > 127 ? x - 256 : x;
    endfunction

    task automatic set_zn(input int v);
        m_res = v & 255;
        m_z = m_res == 0;
        m_n = m_res >= 128;
    endtask

    task automatic addsub(input int x, input int y, input bit sub);
        int t, s;
        t = sub ? x - y : x + y;
        s = sub ? sgn(x) - sgn(y) : sgn(x) + sgn(y);
        m_c = sub ? x < y : t > 255;
        m_v = s > 127 || s < -128;
        set_zn(t);
    endtask

    task automatic m_reset();
        m_pc = 0;
        m_r = '{0, 0, 0, 0};
        {m_z, m_n, m_c, m_v, m_halt, m_pend} = 6'd0;
        m_lat = 0;
    endtask

    task automatic m_exec();
        int ins, op, ra, rb, a, b, nxt, oc;
        if (m_halt) return;
        ins = int'(mm[m_pc]);
        op = ins / 16;
        ra = (ins / 4) % 4;
        rb = ins % 4;
        a = m_r[ra];
        b = m_r[rb];
        nxt = (m_pc + 1) % 256;
        if (m_pend) begin
            m_r[m_lat] = ins;
            m_pend = 0;
        end else begin
            case (op)
                1: m_r[ra] = b;
                2: begin addsub(a, b, 0); m_r[ra] = m_res; end
                3: begin addsub(a, b, 1); m_r[ra] = m_res; end
                4: begin set_zn(a & b); m_r[ra] = m_res; end
                5: begin set_zn(a | b); m_r[ra] = m_res; end
                6: begin set_zn(a ^ b); m_r[ra] = m_res; end
                7: begin
                    if (rb == 0) set_zn(255 - a);
                    else if (rb == 1) addsub(0, a, 1);
                    else if (rb == 2) addsub(a, 1, 0);
                    else addsub(a, 1, 1);
                    m_r[ra] = m_res;
                end
`ifdef SHIFT_ROTATE_EN
                8: begin
                    oc = int'(m_c);
                    if (rb == 0 || rb == 2) begin
                        m_c = a >= 128;
                        set_zn(a * 2 + (rb == 2 ? oc : 0));
                    end else begin
                        m_c = a % 2 == 1;
                        set_zn(a / 2 + (rb == 3 ? oc * 128 : 0));
                    end
                    m_r[ra] = m_res;
                end
`endif
                9: begin m_pend = 1; m_lat = ra; end
                10: m_r[ra] = int'(mm[b]);
                11: mm[b] = 8'(a);
                12: if (ra == 3 || (ra == 0 && m_z) || (ra == 1 && m_n) || (ra == 2 && m_c)) nxt = b;
                13: if (ra == 0) m_c = 1; else if (ra == 1) m_c = 0;
                15: begin m_halt = 1; nxt = m_pc; end
                default: ;
            endcase
        end
        m_pc = nxt;
    endtask

    task automatic step();
        int op, ra, rb;
        bit st;
        logic cwe;
        logic [7:0] ca, cd;
        @(negedge clk);
        op = int'(mm[m_pc]) / 16;
        ra = (int'(mm[m_pc]) / 4) % 4;
        rb = int'(mm[m_pc]) % 4;
        st = !m_halt && !m_pend && op == 11;
        chk("pc", int'(mem_addr_a), m_pc);
        chk("we", int'(mem_write_enable), int'(st));
        chk("addr_b", int'(mem_addr_b), (!m_pend && (op == 10 || op == 11)) ? m_r[rb] : 0);
        if (st) chk("data_b", int'(mem_write_data_b), m_r[ra]);
        {cwe, ca, cd} = {mem_write_enable, mem_addr_b, mem_write_data_b};
        m_exec();
        @(posedge clk);
        #1;
        if (cwe) mem[ca] = cd;
        chk("ccr", int'(CCR_out), int'({m_v, m_c, m_n, m_z}));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_we", int'(mem_write_enable), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        chk("rst_pc", int'(mem_addr_a), 0);
        chk("rst_ccr", int'(CCR_out), 0);
    endtask

    task automatic peek_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            peek_byte = 8'(k * 4);
            peek_en = 1'b1;
            #1;
            pv[k] = int'(mem_write_data_b);
            chk(tag, pv[k], m_r[k]);
        end
        peek_en = 1'b0;
    endtask

    task automatic load();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'd0;
            mm[i] = 8'd0;
        end
        foreach (prog[i]) begin
            mem[i] = prog[i];
            mm[i] = prog[i];
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        m_reset();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'd0;
            mm[i] = 8'd0;
        end
        @(posedge clk);
        #1;
        prog = {8'h90, 8'h05, 8'h94, 8'h03, 8'h28, 8'hF0};
        load();
        do_reset();
        run(8);
        peek_all("t1_regs");
        chk("t1_r0", pv[0], 5);
        chk("t1_r1", pv[1], 3);
        chk("t1_r2", pv[2], 5);
        chk("t1_pc", int'(mem_addr_a), 5);
        chk("t1_ccr", int'(CCR_out), 0);

        prog = {8'h90, 8'h7F, 8'h94, 8'h01, 8'h21, 8'hF0};
        load();
        do_reset();
        run(7);
        peek_all("t2_regs");
        chk("t2_r0", pv[0], 8'h80);
        chk("t2_ccr", int'(CCR_out), 4'b1010);

        prog = {8'h90, 8'h00, 8'h73, 8'hF0};
        load();
        do_reset();
        run(5);
        peek_all("t3_regs");
        chk("t3_r0", pv[0], 8'hFF);
        chk("t3_ccr", int'(CCR_out), 4'b0110);

        prog = {8'h94, 8'h40, 8'h90, 8'hA5, 8'hB1, 8'hA9, 8'hF0};
        load();
        do_reset();
        run(8);
        peek_all("t4_regs");
        chk("t4_r2", pv[2], 8'hA5);
        chk("t4_mem", int'(mem[8'h40]), 8'hA5);

        prog = {8'h9C, 8'h20, 8'h30, 8'hC3};
        load();
        mem[32] = 8'hF0;
        mm[32] = 8'hF0;
        do_reset();
        run(6);
        chk("t5_jz_taken", int'(mem_addr_a), 8'h20);
        prog = {8'h9C, 8'h20, 8'h90, 8'h01, 8'hC3, 8'hF0};
        load();
        do_reset();
        run(7);
        chk("t5_jz_not", int'(mem_addr_a), 5);

        prog = {8'h94, 8'hAA, 8'hF0};
        load();
        do_reset();
        run(1);
        do_reset();
        peek_all("t6_ldm_rst");
        chk("t6_r1", pv[1], 0);
        run(4);
        do_reset();
        run(2);
        prog = {8'hB0, 8'hF0};
        load();
        do_reset();
        do_reset();
        run(3);

        prog = {8'h90, 8'h05, 8'h81, 8'hF0};
        load();
        do_reset();
        run(5);
        peek_all("t7_shift");

        repeat (30) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom_range(0, 255));
                mm[i] = mem[i];
            end
            do_reset();
            for (int s = 0; s < 40; s++) begin
                if ($urandom_range(0, 39) == 0) do_reset();
                else step();
            end
            peek_all("rand_regs");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
